reset_req_ctrl: RTL and testbench
=================================

Name: reset_req_ctrl

Overview:
- Multi-source successor of the single-line reset request extender.
- Samples N_SRC active-low reset request lines and glitch-filters them on the slow-clock enable.
- Drives one stretched reset request output, then applies a hold-off window so its own feedback on a wired-OR line cannot retrigger it.
- Latches which source(s) caused the reset for readback by the board management logic.

Parameters:
- N_SRC, 2: number of request inputs, 1..8.
- FILTER_COUNT, 2: consecutive ce samples with a request low before asserting, 1..15.
- EXTEND_COUNT, 5: ce ticks reset_req_out stays asserted, 1..255.
- HOLDOFF_COUNT, 3: ce ticks after release during which all inputs are ignored, 0..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ce  in  1  slow-clock enable, one clk wide
- req_n  in  N_SRC  active-low reset requests, asynchronous to clk
- mask  in  N_SRC  1 = ignore that source
- cause_clr  in  1  clears cause register, one clk pulse
- reset_req_out  out  1  active-high reset request, drives open-drain pin
- busy  out  1  high in any state other than IDLE
- cause  out  N_SRC  sticky record of sources that triggered a reset

Behaviour:
- Decided interface: one clock, clk; reset rst is asynchronous and active-high.
- On rst: all state registers clear immediately.
  - reset_req_out=0, busy=0, cause=0, counter=0, state=IDLE.
  - Synchronizer flops preset to 1 (deasserted).
- Input path:
  - req_n passes through a 2-flop synchronizer clocked every clk, not gated by ce.
  - act = ~sync_req_n & ~mask, evaluated only on ce cycles.
- FSM states: IDLE, FILTER, ASSERT, HOLDOFF. Transitions and counter updates occur only on clk edges with ce=1.
  - IDLE:
    - |act=1 with FILTER_COUNT=1 → ASSERT; cnt=EXTEND_COUNT-1; cause |= act.
    - |act=1 otherwise → FILTER; cnt=1.
  - FILTER:
    - |act=0 → IDLE.
    - |act=1 and cnt+1==FILTER_COUNT → ASSERT; cnt=EXTEND_COUNT-1; cause |= act.
    - Otherwise cnt++.
  - ASSERT:
    - reset_req_out=1, registered; first high clk after the ce edge that entered ASSERT.
    - cnt==0 → HOLDOFF with cnt=HOLDOFF_COUNT-1, or directly to IDLE if HOLDOFF_COUNT=0.
    - Otherwise cnt--.
    - Inputs are not re-evaluated; no retrigger or extension while asserted.
    - Asserted width is exactly EXTEND_COUNT ce periods.
  - HOLDOFF:
    - Inputs ignored.
    - cnt==0 → IDLE; otherwise cnt--.
- A source still low after HOLDOFF re-enters FILTER from IDLE. Repeated resets are the intended behaviour for a stuck request.
- Counter width is $clog2 of the max of FILTER_COUNT, EXTEND_COUNT and HOLDOFF_COUNT, plus 1. No wrap is possible within the legal ranges.
- cause register:
  - Bits OR in at the FILTER→ASSERT or IDLE→ASSERT edge only.
  - Cleared by cause_clr on any clk; not gated by ce.
  - cause_clr and a set in the same cycle: set wins, and the bits latched that cycle survive.
- mask changes take effect at the next ce sample, including mid-FILTER. Masking the only active source aborts FILTER to IDLE.
- ce held low: FSM frozen, synchronizer keeps running.
- rst mid-ASSERT: output drops asynchronously; no hold-off afterwards.

Optional Feature:
- Macro: RESET_REQ_CTRL_SW_EN.
- With the macro defined:
  - Extra input sw_req (1, a clk pulse from the register block) is added.
  - A request is remembered in a pending flop until consumed by the FSM in IDLE on a ce cycle.
  - Consumption goes directly to ASSERT, bypassing FILTER.
  - cause gains bit N_SRC (width N_SRC+1) recording a software reset.
  - A pending sw_req arriving outside IDLE is held and serviced after HOLDOFF.
- Without the macro: no sw_req port, and cause is N_SRC wide.

Decomposition:
- Shared package/header holds:
  - state encoding constants: IDLE=2'd0, FILTER=2'd1, ASSERT=2'd2, HOLDOFF=2'd3;
  - the counter-width function.
- Natural sub-module: reset_req_sync, a parametrised N-bit 2-flop synchronizer with preset-to-1 on rst, reused by other pin inputs.
- FSM, counter and cause register stay in reset_req_ctrl.

Test Plan:
- Bench defaults: N_SRC=2, FILTER_COUNT=2, EXTEND_COUNT=5, HOLDOFF_COUNT=3, ce every 4 clk.
- Glitch reject: req_n[0] low for 1 ce period → reset_req_out stays 0, cause=2'b00, busy returns to 0.
- Normal request: req_n[1] low for 10 clk then released → reset_req_out high exactly 20 clk (5 ce), cause=2'b10, busy low 12 clk (3 ce) after release.
- Feedback loop: req_n[0] wired to ~reset_req_out OR a 10 clk pulse → exactly one 5-ce assertion, no retrigger after HOLDOFF.
- Mask and stuck source:
  - mask=2'b01 with req_n[0] held low → no assertion.
  - Then mask=2'b00 → repeated 5-ce assertions separated by 3 ce hold-off plus 2 ce filter.
- Simultaneous clear/set: cause_clr pulses on the same clk as the FILTER→ASSERT edge with req_n=2'b00 → cause=2'b11.
- Async reset: rst pulsed 2 clk mid-ASSERT → reset_req_out=0 before the next clk edge, cause=0, state IDLE. With RESET_REQ_CTRL_SW_EN, a sw_req pulse asserts 1 ce later with cause[2]=1.

Source files
------------

// File: rtl/reset_req_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_req_ctrl_pkg                                                         |
// | State encoding and counter sizing shared by the reset request controller.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package reset_req_ctrl_pkg;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_FILTER  = 2'd1;
  localparam logic [1:0] c_ASSERT  = 2'd2;
  localparam logic [1:0] c_HOLDOFF = 2'd3;

  // One spare bit above the largest load value so cnt+1 compares cannot wrap.
  function automatic int cnt_width(input int filt, input int ext, input int hold);
    int m;
    m = filt;
    if (ext > m) m = ext;
    if (hold > m) m = hold;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_req_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_req_sync                                                             |
// | N-bit two-flop synchronizer for active-low pin inputs, presets to 1.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module reset_req_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/reset_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_req_ctrl                                                             |
// | Multi-source filtered, stretched reset request with hold-off and cause     |
// | latch. Define RESET_REQ_CTRL_SW_EN to add the sw_req software request.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module reset_req_ctrl
  import reset_req_ctrl_pkg::*;
#(
  parameter int N_SRC         = 2,
  parameter int FILTER_COUNT  = 2,
  parameter int EXTEND_COUNT  = 5,
  parameter int HOLDOFF_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [N_SRC-1:0] req_n,
  input  logic [N_SRC-1:0] mask,
  input  logic             cause_clr,
`ifdef RESET_REQ_CTRL_SW_EN
  input  logic             sw_req,
  output logic [N_SRC:0]   cause,
`else
  output logic [N_SRC-1:0] cause,
`endif
  output logic             reset_req_out,
  output logic             busy
);

`ifdef RESET_REQ_CTRL_SW_EN
  localparam int c_CW = N_SRC + 1;
`else
  localparam int c_CW = N_SRC;
`endif

  localparam int             CNT_W       = cnt_width(FILTER_COUNT, EXTEND_COUNT, HOLDOFF_COUNT);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_FILT_CNT = CNT_W'(FILTER_COUNT);
  localparam logic [CNT_W-1:0] c_EXT_LOAD = CNT_W'(EXTEND_COUNT - 1);
  localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'((HOLDOFF_COUNT > 0) ? HOLDOFF_COUNT - 1 : 0);
  localparam bit               c_HOLD_EN   = (HOLDOFF_COUNT > 0);

  logic [N_SRC-1:0] w_req_n_sync;
  logic [N_SRC-1:0] w_act;
  logic             w_any_act;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_SRC-1:0] w_src_set;
  logic [c_CW-1:0]  w_cause_set;
  logic [c_CW-1:0]  r_cause;
  logic             r_req_out;
  logic             r_busy;
  logic             w_req_out_nxt;
  logic             w_busy_nxt;

`ifdef RESET_REQ_CTRL_SW_EN
  logic r_sw_pend;
  logic w_sw_take;
`endif

  reset_req_sync #(
    .WIDTH (N_SRC)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (req_n),
    .o_q (w_req_n_sync)
  );

  assign w_act     = ~w_req_n_sync & ~mask;
  assign w_any_act = |w_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_req_out <= 1'b0;
      r_busy    <= 1'b0;
      r_cause   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req_out <= w_req_out_nxt;
      r_busy    <= w_busy_nxt;
      // A set in the same cycle as a clear survives the clear.
      r_cause   <= (cause_clr ? '0 : r_cause) | w_cause_set;
    end
  end

`ifdef RESET_REQ_CTRL_SW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_pend <= 1'b0;
    end else begin
      r_sw_pend <= (r_sw_pend & ~w_sw_take) | sw_req;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_src_set   = '0;
`ifdef RESET_REQ_CTRL_SW_EN
    w_sw_take   = 1'b0;
`endif
    if (ce) begin
      case (r_state)
        c_IDLE: begin
`ifdef RESET_REQ_CTRL_SW_EN
          if (r_sw_pend) begin
            w_state_nxt = c_ASSERT;
            w_cnt_nxt   = c_EXT_LOAD;
            w_sw_take   = 1'b1;
          end else
`endif
          if (w_any_act) begin
            if (FILTER_COUNT == 1) begin
              w_state_nxt = c_ASSERT;
              w_cnt_nxt   = c_EXT_LOAD;
              w_src_set   = w_act;
            end else begin
              w_state_nxt = c_FILTER;
              w_cnt_nxt   = c_ONE;
            end
          end
        end
        c_FILTER: begin
          if (!w_any_act) begin
            w_state_nxt = c_IDLE;
          end else if (r_cnt + c_ONE == c_FILT_CNT) begin
            w_state_nxt = c_ASSERT;
            w_cnt_nxt   = c_EXT_LOAD;
            w_src_set   = w_act;
          end else begin
            w_cnt_nxt   = r_cnt + c_ONE;
          end
        end
        c_ASSERT: begin
          if (r_cnt == '0) begin
            if (c_HOLD_EN) begin
              w_state_nxt = c_HOLDOFF;
              w_cnt_nxt   = c_HOLD_LOAD;
            end else begin
              w_state_nxt = c_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_ONE;
          end
        end
        c_HOLDOFF: begin
          if (r_cnt == '0) begin
            w_state_nxt = c_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - c_ONE;
          end
        end
        default: begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_req_out_nxt = (w_state_nxt == c_ASSERT);
    w_busy_nxt    = (w_state_nxt != c_IDLE);
    w_cause_set   = '0;
    w_cause_set[N_SRC-1:0] = w_src_set;
`ifdef RESET_REQ_CTRL_SW_EN
    w_cause_set[N_SRC] = w_sw_take;
`endif
  end

  assign reset_req_out = r_req_out;
  assign busy          = r_busy;
  assign cause         = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_req_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reset_req_ctrl                                                          |
// | Scenario bench for reset_req_ctrl with an expected-pulse queue.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_reset_req_ctrl;

  localparam int N_SRC         = 2;
  localparam int FILTER_COUNT  = 2;
  localparam int EXTEND_COUNT  = 5;
  localparam int HOLDOFF_COUNT = 3;
  localparam int CE_DIV        = 4;
  localparam int PULSE_CLK     = EXTEND_COUNT * CE_DIV;
  localparam int HOLD_CLK      = HOLDOFF_COUNT * CE_DIV;
  localparam int REARM_CLK     = (HOLDOFF_COUNT + FILTER_COUNT) * CE_DIV;
`ifdef RESET_REQ_CTRL_SW_EN
  localparam int CW = N_SRC + 1;
`else
  localparam int CW = N_SRC;
`endif

  typedef struct {
    int            width;
    logic [CW-1:0] cause;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic             ce = 1'b0;
  logic             cause_clr;
  logic [N_SRC-1:0] tb_req_n;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] req_n;
  logic             fb_en;
  logic             reset_req_out;
  logic             busy;
  logic [CW-1:0]    cause;
`ifdef RESET_REQ_CTRL_SW_EN
  logic             sw_req = 1'b0;
`endif
  int               ce_div = 0;

  // Source 0 optionally wired-OR with the controller's own open-drain output.
  assign req_n = {tb_req_n[1], tb_req_n[0] & ~(fb_en & reset_req_out)};

  reset_req_ctrl #(
    .N_SRC         (N_SRC),
    .FILTER_COUNT  (FILTER_COUNT),
    .EXTEND_COUNT  (EXTEND_COUNT),
    .HOLDOFF_COUNT (HOLDOFF_COUNT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .req_n         (req_n),
    .mask          (mask),
    .cause_clr     (cause_clr),
`ifdef RESET_REQ_CTRL_SW_EN
    .sw_req        (sw_req),
`endif
    .reset_req_out (reset_req_out),
    .busy          (busy),
    .cause         (cause)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ce_div = (ce_div + 1) % CE_DIV;
    ce     = (ce_div == 0);
  end

  task automatic measure_pulse(input int max_wait, output int gap, output int width, output bit ok);
    gap   = 0;
    width = 0;
    ok    = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(posedge clk); #1;
      if (reset_req_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
    if (ok) begin
      width = 1;
      while (width < 400) begin
        @(posedge clk); #1;
        if (reset_req_out !== 1'b1) break;
        width++;
      end
    end
  endtask

  task automatic wait_idle(input int max_wait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic watch(input int cycles, output bit seen_out, output bit seen_busy);
    seen_out  = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (reset_req_out !== 1'b0) seen_out = 1'b1;
      if (busy !== 1'b0) seen_busy = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    cause_clr = 1'b1;
    @(posedge clk); #1;
    cause_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (reset_req_out !== 1'b0) begin n_fail++; $display("FAIL rst_out: got %b want 0", reset_req_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++;
    if (cause !== '0) begin n_fail++; $display("FAIL rst_cause: got %b want 0", cause); end
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (reset_req_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle: out=%b busy=%b want 0/0", reset_req_out, busy);
    end
  endtask

  task automatic test_glitch();
    bit so, sb_;
    @(posedge clk); #1;
    tb_req_n[0] = 1'b0;
    repeat (CE_DIV) @(posedge clk);
    #1;
    tb_req_n[0] = 1'b1;
    watch(40, so, sb_);
    n_checks++;
    if (so !== 1'b0) begin n_fail++; $display("FAIL glitch_out: asserted=%b want 0", so); end
    n_checks++;
    if (sb_ !== 1'b1) begin n_fail++; $display("FAIL glitch_filter_busy: seen=%b want 1", sb_); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    n_checks++;
    if (cause !== '0) begin n_fail++; $display("FAIL glitch_cause: got %b want 0", cause); end
  endtask

  task automatic test_normal();
    int gap, width, hold;
    bit ok;
    exp_t e;
    sb.push_back('{width: PULSE_CLK, cause: CW'(2'b10)});
    fork
      begin
        @(posedge clk); #1;
        tb_req_n[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tb_req_n[1] = 1'b1;
      end
      measure_pulse(60, gap, width, ok);
    join
    e = sb.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL normal_seen: no assertion within bound"); end
    n_checks++;
    if (width !== e.width) begin n_fail++; $display("FAIL normal_width: got %0d clk want %0d", width, e.width); end
    n_checks++;
    if (cause !== e.cause) begin n_fail++; $display("FAIL normal_cause: got %b want %b", cause, e.cause); end
    hold = 0;
    while (busy === 1'b1 && hold < 100) begin
      hold++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (hold !== HOLD_CLK) begin n_fail++; $display("FAIL normal_holdoff: got %0d clk want %0d", hold, HOLD_CLK); end
  endtask

  task automatic test_feedback();
    int gap, width;
    bit ok, so, sb_;
    exp_t e;
    pulse_clr();
    n_checks++;
    if (cause !== '0) begin n_fail++; $display("FAIL clr_cause: got %b want 0", cause); end
    fb_en = 1'b1;
    sb.push_back('{width: PULSE_CLK, cause: CW'(2'b01)});
    fork
      begin
        @(posedge clk); #1;
        tb_req_n[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tb_req_n[0] = 1'b1;
      end
      measure_pulse(60, gap, width, ok);
    join
    e = sb.pop_front();
    n_checks++;
    if (!ok || width !== e.width) begin n_fail++; $display("FAIL fb_width: seen=%b got %0d clk want %0d", ok, width, e.width); end
    n_checks++;
    if (cause !== e.cause) begin n_fail++; $display("FAIL fb_cause: got %b want %b", cause, e.cause); end
    watch(80, so, sb_);
    n_checks++;
    if (so !== 1'b0) begin n_fail++; $display("FAIL fb_retrigger: asserted=%b want 0", so); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fb_busy_end: got %b want 0", busy); end
    fb_en = 1'b0;
  endtask

  task automatic test_mask_stuck();
    int gap, width;
    bit ok, so, sb_;
    exp_t e;
    @(posedge clk); #1;
    mask        = 2'b01;
    tb_req_n[0] = 1'b0;
    watch(40, so, sb_);
    n_checks++;
    if (so !== 1'b0 || sb_ !== 1'b0) begin n_fail++; $display("FAIL mask_ignore: out=%b busy=%b want 0/0", so, sb_); end
    mask = 2'b00;
    sb.push_back('{width: PULSE_CLK, cause: CW'(2'b01)});
    sb.push_back('{width: PULSE_CLK, cause: CW'(2'b01)});
    measure_pulse(40, gap, width, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || width !== e.width) begin n_fail++; $display("FAIL stuck_w1: seen=%b got %0d want %0d", ok, width, e.width); end
    measure_pulse(80, gap, width, ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || width !== e.width) begin n_fail++; $display("FAIL stuck_w2: seen=%b got %0d want %0d", ok, width, e.width); end
    // The sample that ended the first pulse is the first low clock of the gap.
    n_checks++;
    if (gap + 1 !== REARM_CLK) begin n_fail++; $display("FAIL stuck_gap: got %0d clk want %0d", gap + 1, REARM_CLK); end
    n_checks++;
    if (cause !== e.cause) begin n_fail++; $display("FAIL stuck_cause: got %b want %b", cause, e.cause); end
    tb_req_n = 2'b11;
    wait_idle(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stuck_release: busy=%b want 0", busy); end
  endtask

  task automatic test_clear_set();
    int gap, width;
    bit ok, found;
    exp_t e;
    @(posedge clk); #1;
    tb_req_n = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || reset_req_out !== 1'b0) begin n_fail++; $display("FAIL cs_filter: busy_seen=%b out=%b want 1/0", found, reset_req_out); end
    for (int i = 0; i < 2 * CE_DIV; i++) begin
      @(negedge clk); #1;
      if (ce) break;
    end
    cause_clr = 1'b1;
    sb.push_back('{width: PULSE_CLK, cause: CW'(2'b11)});
    fork
      begin
        @(posedge clk); #1;
        cause_clr = 1'b0;
      end
      measure_pulse(20, gap, width, ok);
    join
    e = sb.pop_front();
    n_checks++;
    if (!ok || gap !== 0 || width !== e.width) begin
      n_fail++; $display("FAIL cs_pulse: seen=%b gap=%0d width=%0d want 1/0/%0d", ok, gap, width, e.width);
    end
    n_checks++;
    if (cause !== e.cause) begin n_fail++; $display("FAIL cs_cause: got %b want %b", cause, e.cause); end
    tb_req_n = 2'b11;
    wait_idle(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cs_release: busy=%b want 0", busy); end
  endtask

  task automatic test_async_rst();
    bit found, so, sb_;
    @(posedge clk); #1;
    tb_req_n[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (reset_req_out === 1'b1) begin found = 1'b1; break; end
    end
    tb_req_n[1] = 1'b1;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL arst_assert: no assertion within bound"); end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (reset_req_out !== 1'b0) begin n_fail++; $display("FAIL arst_out: got %b want 0 before next edge", reset_req_out); end
    n_checks++;
    if (busy !== 1'b0 || cause !== '0) begin n_fail++; $display("FAIL arst_state: busy=%b cause=%b want 0/0", busy, cause); end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    watch(40, so, sb_);
    n_checks++;
    if (so !== 1'b0 || sb_ !== 1'b0) begin n_fail++; $display("FAIL arst_after: out=%b busy=%b want 0/0", so, sb_); end
  endtask

`ifdef RESET_REQ_CTRL_SW_EN
  task automatic test_sw();
    int gap, width;
    bit ok;
    exp_t e;
    sb.push_back('{width: PULSE_CLK, cause: CW'(3'b100)});
    fork
      begin
        @(posedge clk); #1;
        sw_req = 1'b1;
        @(posedge clk); #1;
        sw_req = 1'b0;
      end
      measure_pulse(40, gap, width, ok);
    join
    e = sb.pop_front();
    n_checks++;
    if (!ok || gap > CE_DIV + 2) begin n_fail++; $display("FAIL sw_latency: seen=%b gap=%0d want <=%0d", ok, gap, CE_DIV + 2); end
    n_checks++;
    if (width !== e.width) begin n_fail++; $display("FAIL sw_width: got %0d want %0d", width, e.width); end
    n_checks++;
    if (cause !== e.cause) begin n_fail++; $display("FAIL sw_cause: got %b want %b", cause, e.cause); end
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sw_idle: busy=%b want 0", busy); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    cause_clr = 1'b0;
    tb_req_n  = '1;
    mask      = '0;
    fb_en     = 1'b0;
    test_reset();
    test_glitch();
    test_normal();
    test_feedback();
    test_mask_stuck();
    test_clear_set();
    test_async_rst();
`ifdef RESET_REQ_CTRL_SW_EN
    test_sw();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
